parking_gate_controller: RTL and testbench

Sequencing controller for the 15-slot parking lot: arbitrates the entry and exit gates, assigns each arriving car the lowest-numbered free slot, and releases slots on exit. It owns the 15-bit occupancy register that feeds the occupancy counter and seven-segment display path. It times each gate opening and guarantees only one gate moves at a time.

---
 rtl/parking_gate_controller_if.sv | 28 ++
 rtl/parking_gate_controller.sv | 174 +++++++++++++++++
 tb/tb_parking_gate_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_controller_if.sv
// Request/grant and status bundle between the parking lot sequencer and the
// gate/display side. The requester drives the master modport; the controller uses the slave modport.
interface parking_gate_controller_if;
    logic        entry_req;
    logic        exit_req;
    logic [3:0]  exit_slot;
    logic        entry_ack;
    logic [3:0]  entry_slot;
    logic        exit_ack;
    logic        exit_err;
    logic        entry_gate;
    logic        exit_gate;
    logic [14:0] cars;
    logic [3:0]  count;
    logic        full;

    modport master (
        output entry_req, exit_req, exit_slot,
        input  entry_ack, entry_slot, exit_ack, exit_err,
        input  entry_gate, exit_gate, cars, count, full
    );

    modport slave (
        input  entry_req, exit_req, exit_slot,
        output entry_ack, entry_slot, exit_ack, exit_err,
        output entry_gate, exit_gate, cars, count, full
    );
endinterface

// File: rtl/parking_gate_controller.sv
// Entry/exit gate sequencer for a 15-slot lot: grants one gate at a time,
// assigns the lowest free slot on entry and releases the slot on exit.
module parking_gate_controller #(
    parameter int unsigned GATE_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    parking_gate_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        EXIT  = 2'd2
    } state_t;

    localparam logic [7:0] LOAD_VAL = 8'(GATE_CYCLES - 1);

    function automatic logic [14:0] slot_mask(input logic [3:0] slot);
        logic [14:0] m;
        m = 15'd0;
        for (int i = 0; i < 15; i++) begin
            if (slot == 4'(i)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Scans from the top so the last hit, i.e. the lowest free index, wins.
    function automatic logic [3:0] lowest_free(input logic [14:0] c);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 14; i >= 0; i--) begin
            if (!c[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [14:0] c);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 15; i++) begin
            n = n + {3'b000, c[i]};
        end
        return n;
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        last_entry_r, last_entry_s;
    logic [14:0] cars_r, cars_s;
    logic        entry_ack_r, entry_ack_s;
    logic [3:0]  entry_slot_r, entry_slot_s;
    logic        exit_ack_r, exit_ack_s;
    logic        exit_err_r, exit_err_s;
    logic        entry_gate_r, entry_gate_s;
    logic        exit_gate_r, exit_gate_s;

    logic        full_s;
    logic [14:0] exit_mask_s;
    logic        exit_valid_s;
    logic        entry_elig_s;
    logic        grant_exit_s;
    logic        grant_entry_s;

    assign full_s        = &cars_r;
    assign exit_mask_s   = slot_mask(bus.exit_slot);
    assign exit_valid_s  = bus.exit_req & (|(cars_r & exit_mask_s));
    assign entry_elig_s  = bus.entry_req & ~full_s;
    // On a tie the side that was not served last time wins.
    assign grant_exit_s  = exit_valid_s & (~entry_elig_s | last_entry_r);
    assign grant_entry_s = entry_elig_s & ~grant_exit_s;

    // Next-state, grant decisions and gate timing.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        last_entry_s = last_entry_r;
        cars_s       = cars_r;
        entry_ack_s  = 1'b0;
        entry_slot_s = 4'd0;
        exit_ack_s   = 1'b0;
        exit_err_s   = 1'b0;
        entry_gate_s = entry_gate_r;
        exit_gate_s  = exit_gate_r;

        case (state_r)
            IDLE: begin
                exit_err_s = bus.exit_req & ~exit_valid_s;
                if (grant_entry_s) begin
                    cars_s       = cars_r | (~cars_r & (cars_r + 15'd1));
                    entry_slot_s = lowest_free(cars_r);
                    entry_ack_s  = 1'b1;
                    entry_gate_s = 1'b1;
                    exit_gate_s  = 1'b0;
                    cnt_s        = LOAD_VAL;
                    last_entry_s = 1'b1;
                    state_s      = ENTRY;
                end else if (grant_exit_s) begin
                    cars_s       = cars_r & ~exit_mask_s;
                    exit_ack_s   = 1'b1;
                    exit_gate_s  = 1'b1;
                    entry_gate_s = 1'b0;
                    cnt_s        = LOAD_VAL;
                    last_entry_s = 1'b0;
                    state_s      = EXIT;
                end else begin
                    entry_gate_s = 1'b0;
                    exit_gate_s  = 1'b0;
                end
            end
            ENTRY, EXIT: begin
                if (cnt_r == 8'd0) begin
                    entry_gate_s = 1'b0;
                    exit_gate_s  = 1'b0;
                    state_s      = IDLE;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            default: begin
                entry_gate_s = 1'b0;
                exit_gate_s  = 1'b0;
                cnt_s        = 8'd0;
                state_s      = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            last_entry_r <= 1'b1;
            cars_r       <= 15'd0;
            entry_ack_r  <= 1'b0;
            entry_slot_r <= 4'd0;
            exit_ack_r   <= 1'b0;
            exit_err_r   <= 1'b0;
            entry_gate_r <= 1'b0;
            exit_gate_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            last_entry_r <= last_entry_s;
            cars_r       <= cars_s;
            entry_ack_r  <= entry_ack_s;
            entry_slot_r <= entry_slot_s;
            exit_ack_r   <= exit_ack_s;
            exit_err_r   <= exit_err_s;
            entry_gate_r <= entry_gate_s;
            exit_gate_r  <= exit_gate_s;
        end
    end

    assign bus.entry_ack  = entry_ack_r;
    assign bus.entry_slot = entry_slot_r;
    assign bus.exit_ack   = exit_ack_r;
    assign bus.exit_err   = exit_err_r;
    assign bus.entry_gate = entry_gate_r;
    assign bus.exit_gate  = exit_gate_r;
    assign bus.cars       = cars_r;
    assign bus.count      = popcount(cars_r);
    assign bus.full       = full_s;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: two instances (GATE_CYCLES 8 and 1) share
// stimulus and are compared every cycle against a slot-array/gate-timer model.
module tb_parking_gate_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       entry_req;
    logic       exit_req;
    logic [3:0] exit_slot;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    parking_gate_controller_if bus0 ();
    parking_gate_controller_if bus1 ();

    assign bus0.entry_req = entry_req;
    assign bus0.exit_req  = exit_req;
    assign bus0.exit_slot = exit_slot;
    assign bus1.entry_req = entry_req;
    assign bus1.exit_req  = exit_req;
    assign bus1.exit_slot = exit_slot;

    parking_gate_controller #(.GATE_CYCLES(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    parking_gate_controller #(.GATE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Behavioural model: per unit a slot array, a tie flag and the number of
    // gate-open cycles left (0 means the controller is free to take requests).
    int         m_g[2] = '{8, 1};
    bit         m_occ[2][15];
    bit         m_last[2];
    int         m_left[2];
    bit         m_eg[2], m_xg[2], m_eack[2], m_xack[2], m_xerr[2];
    logic [3:0] m_eslot[2];

    task automatic model_step(input int u);
        bit full, valid, ent, gx, ge;
        int k;
        m_eack[u] = 1'b0; m_xack[u] = 1'b0; m_xerr[u] = 1'b0; m_eslot[u] = 4'd0;
        if (rst) begin
            for (int i = 0; i < 15; i++) m_occ[u][i] = 1'b0;
            m_last[u] = 1'b1; m_left[u] = 0; m_eg[u] = 1'b0; m_xg[u] = 1'b0;
        end else if (m_left[u] > 0) begin
            m_left[u] = m_left[u] - 1;
            if (m_left[u] == 0) begin m_eg[u] = 1'b0; m_xg[u] = 1'b0; end
        end else begin
            full = 1'b1;
            for (int i = 0; i < 15; i++) if (!m_occ[u][i]) full = 1'b0;
            valid = exit_req && (exit_slot < 4'd15) && m_occ[u][exit_slot];
            ent   = entry_req && !full;
            gx    = valid && (!ent || m_last[u]);
            ge    = ent && !gx;
            m_xerr[u] = exit_req && !valid;
            if (ge) begin
                k = -1;
                for (int i = 0; i < 15; i++) if (!m_occ[u][i] && k < 0) k = i;
                m_occ[u][k] = 1'b1; m_eack[u] = 1'b1; m_eslot[u] = 4'(k);
                m_eg[u] = 1'b1; m_left[u] = m_g[u]; m_last[u] = 1'b1;
            end else if (gx) begin
                m_occ[u][exit_slot] = 1'b0; m_xack[u] = 1'b1;
                m_xg[u] = 1'b1; m_left[u] = m_g[u]; m_last[u] = 1'b0;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (unit %0d) cycle %0d: got 0x%0h, required 0x%0h", name, u, cyc, act, exp);
        end
    endtask

    task automatic cmp_unit(input int u, input logic eack, input logic [3:0] eslot,
                            input logic xack, input logic xerr, input logic eg, input logic xg,
                            input logic [14:0] cars, input logic [3:0] cnt, input logic full);
        logic [14:0] ec;
        int n;
        n = 0;
        for (int i = 0; i < 15; i++) begin ec[i] = m_occ[u][i]; n += int'(m_occ[u][i]); end
        check("entry_ack",  u, eack,  m_eack[u]);
        check("entry_slot", u, eslot, m_eslot[u]);
        check("exit_ack",   u, xack,  m_xack[u]);
        check("exit_err",   u, xerr,  m_xerr[u]);
        check("entry_gate", u, eg,    m_eg[u]);
        check("exit_gate",  u, xg,    m_xg[u]);
        check("cars",       u, cars,  ec);
        check("count",      u, cnt,   n);
        check("full",       u, full,  (n == 15));
        check("gates_excl", u, eg & xg, 1'b0);
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            cmp_unit(0, bus0.entry_ack, bus0.entry_slot, bus0.exit_ack, bus0.exit_err,
                     bus0.entry_gate, bus0.exit_gate, bus0.cars, bus0.count, bus0.full);
            cmp_unit(1, bus1.entry_ack, bus1.entry_slot, bus1.exit_ack, bus1.exit_err,
                     bus1.entry_gate, bus1.exit_gate, bus1.cars, bus1.count, bus1.full);
        end
    end

    // which: 0 entry_ack, 1 exit_ack, 2 full, 3 both gates low, 4 any ack (unit 0)
    task automatic wait_sig(input int which, input int max_cyc, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = bus0.entry_ack;
                1:       hit = bus0.exit_ack;
                2:       hit = bus0.full;
                3:       hit = !bus0.entry_gate && !bus0.exit_gate;
                4:       hit = bus0.entry_ack || bus0.exit_ack;
                default: hit = 1'b1;
            endcase
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_%s: event not seen within %0d cycles", name, max_cyc);
        end
    endtask

    initial begin
        int gate_len, b1_acks, acks;
        rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_slot = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_cars", 0, bus0.cars, 15'h0000);
        check("rst_count", 0, bus0.count, 4'd0);
        check("rst_full", 0, bus0.full, 1'b0);
        check("rst_gate", 0, bus0.entry_gate | bus0.exit_gate, 1'b0);
        check("rst_slot", 0, bus0.entry_slot, 4'd0);

        // First entry, gate length and back-to-back spacing
        rst = 1'b0; entry_req = 1'b1;
        @(negedge clk);
        check("first_ack", 0, bus0.entry_ack, 1'b1);
        check("first_slot", 0, bus0.entry_slot, 4'd0);
        check("first_cars", 0, bus0.cars, 15'h0001);
        check("first_count", 0, bus0.count, 4'd1);
        check("first_ack", 1, bus1.entry_ack, 1'b1);
        gate_len = 0; b1_acks = 0;
        for (int i = 0; i < 8; i++) begin
            gate_len += int'(bus0.entry_gate);
            b1_acks  += int'(bus1.entry_ack);
            @(negedge clk);
        end
        check("gate_len", 0, gate_len, 8);
        check("gate_closed", 0, bus0.entry_gate, 1'b0);
        check("g1_ack_spacing", 1, b1_acks, 4);
        @(negedge clk);
        check("second_ack", 0, bus0.entry_ack, 1'b1);
        check("second_slot", 0, bus0.entry_slot, 4'd1);

        // Fill the lot, entry must then wait
        wait_sig(2, 200, "full");
        check("full_count", 0, bus0.count, 4'd15);
        check("full_cars", 0, bus0.cars, 15'h7FFF);
        acks = 0;
        repeat (50) begin @(negedge clk); acks += int'(bus0.entry_ack); end
        check("full_no_ack", 0, acks, 0);
        exit_req = 1'b1; exit_slot = 4'd7;
        wait_sig(1, 20, "exit7");
        check("exit7_cars", 0, bus0.cars, 15'h7F7F);
        exit_req = 1'b0;
        wait_sig(0, 20, "reentry");
        check("reentry_slot", 0, bus0.entry_slot, 4'd7);
        check("reentry_full", 0, bus0.full, 1'b1);
        entry_req = 1'b0;
        wait_sig(3, 20, "idle");

        // Ties: occupy slots 0..3, then alternate exit, entry, exit, entry
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            entry_req = 1'b1;
            wait_sig(0, 5, "fill");
            entry_req = 1'b0;
            wait_sig(3, 20, "idle");
        end
        for (int r = 0; r < 4; r++) begin
            entry_req = 1'b1; exit_req = 1'b1; exit_slot = 4'(3 - r);
            wait_sig(4, 5, "tie");
            check("tie_exit", 0, bus0.exit_ack, (r % 2 == 0));
            check("tie_entry", 0, bus0.entry_ack, (r % 2 == 1));
            entry_req = 1'b0; exit_req = 1'b0;
            wait_sig(3, 20, "idle");
        end
        check("tie_cars", 0, bus0.cars, 15'h000F);

        // Invalid exits
        exit_req = 1'b1; exit_slot = 4'd15;
        @(negedge clk);
        check("err15", 0, bus0.exit_err, 1'b1);
        check("err15_cars", 0, bus0.cars, 15'h000F);
        check("err15_gate", 0, bus0.entry_gate | bus0.exit_gate, 1'b0);
        exit_req = 1'b0;
        @(negedge clk);
        exit_req = 1'b1; exit_slot = 4'd5;
        @(negedge clk);
        check("err_empty", 0, bus0.exit_err, 1'b1);
        check("err_empty_gate", 0, bus0.entry_gate | bus0.exit_gate, 1'b0);
        exit_req = 1'b0;
        @(negedge clk);
        entry_req = 1'b1; exit_req = 1'b1; exit_slot = 4'd15;
        @(negedge clk);
        check("err_with_entry_err", 0, bus0.exit_err, 1'b1);
        check("err_with_entry_ack", 0, bus0.entry_ack, 1'b1);
        check("err_with_entry_slot", 0, bus0.entry_slot, 4'd4);
        entry_req = 1'b0; exit_req = 1'b0;
        wait_sig(3, 20, "idle");

        // Reset in the third cycle of an open entry gate
        entry_req = 1'b1;
        wait_sig(0, 5, "pre_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_gate", 0, bus0.entry_gate, 1'b0);
        check("midrst_cars", 0, bus0.cars, 15'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_ack", 0, bus0.entry_ack, 1'b1);
        check("postrst_slot", 0, bus0.entry_slot, 4'd0);
        entry_req = 1'b0;
        wait_sig(3, 20, "idle");

        // Random traffic
        repeat (3000) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 199) == 0);
            entry_req = 1'($urandom_range(0, 1));
            exit_req  = ($urandom_range(0, 2) == 0);
            exit_slot = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
